// File: rtl/ysyx_25040111_rd_arbiter.sv
// ysyx_25040111_rd_arbiter: round-robin AXI read arbiter for IFU (m0) and LSU (m1) onto one slave port.
// One transaction in flight; R-channel beat count and ID are checked against the latched request.
module ysyx_25040111_rd_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    input  logic [31:0] m0_araddr,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic [1:0]  m0_arburst,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rlast,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    input  logic [31:0] m1_araddr,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic [1:0]  m1_arburst,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rlast,
    output logic        s_arvalid,
    input  logic        s_arready,
    output logic [31:0] s_araddr,
    output logic [3:0]  s_arid,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    input  logic        s_rvalid,
    output logic        s_rready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rlast,
    input  logic [3:0]  s_rid,
    output logic        proto_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t     state, state_nxt;
    logic       grant, last_grant, grant_nxt, any_req, r_hs, beat_bad;
    logic [7:0] arlen_q, beat_cnt;

    assign any_req   = m0_arvalid | m1_arvalid;
    assign grant_nxt = (m0_arvalid & m1_arvalid) ? ~last_grant : m1_arvalid;
    assign r_hs      = (state == DATA) & s_rvalid & s_rready;
    // A beat is bad if rlast disagrees with the latched length or the ID is not ours
    assign beat_bad  = (s_rlast ? (beat_cnt != arlen_q) : (beat_cnt == arlen_q)) | (s_rid != {3'b0, grant});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = any_req ? ADDR : IDLE;
            ADDR:    state_nxt = s_arready ? DATA : ADDR;
            DATA:    state_nxt = (r_hs & s_rlast) ? IDLE : DATA;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_arvalid  = state == ADDR;
        s_araddr   = grant ? m1_araddr : m0_araddr;
        s_arlen    = grant ? m1_arlen : m0_arlen;
        s_arsize   = grant ? m1_arsize : m0_arsize;
        s_arburst  = grant ? m1_arburst : m0_arburst;
        s_arid     = {3'b0, grant};
        m0_arready = (state == ADDR) & ~grant & s_arready;
        m1_arready = (state == ADDR) & grant & s_arready;
        s_rready   = (state == DATA) & (grant ? m1_rready : m0_rready);
        m0_rvalid  = (state == DATA) & ~grant & s_rvalid;
        m1_rvalid  = (state == DATA) & grant & s_rvalid;
        m0_rdata   = s_rdata;
        m1_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m1_rresp   = s_rresp;
        m0_rlast   = s_rlast;
        m1_rlast   = s_rlast;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            arlen_q    <= 8'd0;
            beat_cnt   <= 8'd0;
            proto_err  <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                grant   <= grant_nxt;
                arlen_q <= grant_nxt ? m1_arlen : m0_arlen;
            end
            if (state == ADDR && s_arready) beat_cnt <= 8'd0;
            else if (r_hs)                  beat_cnt <= beat_cnt + 8'd1;
            if (r_hs && s_rlast) last_grant <= grant;
            if (r_hs && beat_bad) proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ysyx_25040111_rd_arbiter.sv
// tb_ysyx_25040111_rd_arbiter: directed checks of arbitration, pass-through, beat checking and reset abort.
module tb_ysyx_25040111_rd_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [31:0] m0_araddr, m0_rdata;
    logic [7:0]  m0_arlen;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_arburst, m0_rresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [31:0] m1_araddr, m1_rdata;
    logic [7:0]  m1_arlen;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_arburst, m1_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, proto_err;
    logic [31:0] s_araddr, s_rdata;
    logic [3:0]  s_arid, s_rid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;
    logic        exp_perr;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clock = ~clock;

    ysyx_25040111_rd_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid), .proto_err(proto_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // req[0]=m0, req[1]=m1; g is the hand-computed winner; early_last/abort_at are beat indices or -1
    task automatic txn(input logic [1:0] req, input logic g, input int ar_wait, input int early_last,
                       input bit toggle, input int abort_at, input logic [31:0] base);
        logic [7:0] len;
        int         b, guard, exp_beats;
        bit         done;
        logic       rr;
        m0_arvalid = req[0];
        m1_arvalid = req[1];
        len = g ? m1_arlen : m0_arlen;
        @(posedge clock); #1;
        for (int i = 0; i < ar_wait; i++) begin
            check("ar_valid_wait", {31'b0, s_arvalid}, 1);
            check("ar_addr_hold", s_araddr, g ? m1_araddr : m0_araddr);
            check("ar_len_hold", {24'b0, s_arlen}, {24'b0, len});
            check("ar_size_hold", {29'b0, s_arsize}, {29'b0, g ? m1_arsize : m0_arsize});
            check("ar_ready_wait", {31'b0, g ? m1_arready : m0_arready}, 0);
            @(posedge clock); #1;
        end
        s_arready = 1'b1;
        #1;
        check("ar_valid", {31'b0, s_arvalid}, 1);
        check("ar_id", {28'b0, s_arid}, {31'b0, g});
        check("ar_ready_grant", {31'b0, g ? m1_arready : m0_arready}, 1);
        check("ar_ready_other", {31'b0, g ? m0_arready : m1_arready}, 0);
        @(posedge clock); #1;
        s_arready = 1'b0;
        if (g) m1_arvalid = 1'b0;
        else   m0_arvalid = 1'b0;
        b = 0;
        guard = 0;
        done = 0;
        while (!done && guard < 64) begin
            guard++;
            rr = toggle ? guard[0] : 1'b1;
            if (g) m1_rready = rr;
            else   m0_rready = rr;
            s_rvalid = 1'b1;
            s_rdata  = base + b;
            s_rid    = {3'b0, g};
            s_rresp  = 2'(b);
            s_rlast  = (early_last >= 0) ? (b == early_last) : (b == int'(len));
            if (b == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_s_arvalid", {31'b0, s_arvalid}, 0);
                check("abort_s_rready", {31'b0, s_rready}, 0);
                check("abort_m0_rvalid", {31'b0, m0_rvalid}, 0);
                check("abort_m1_rvalid", {31'b0, m1_rvalid}, 0);
                check("abort_proto_err", {31'b0, proto_err}, 0);
                s_rvalid = 1'b0;
                s_rlast = 1'b0;
                m0_rready = 1'b0;
                m1_rready = 1'b0;
                @(posedge clock); #1;
                reset = 1'b1;
                return;
            end
            #1;
            check("r_ready_mirror", {31'b0, s_rready}, {31'b0, rr});
            check("r_valid_grant", {31'b0, g ? m1_rvalid : m0_rvalid}, 1);
            check("r_valid_other", {31'b0, g ? m0_rvalid : m1_rvalid}, 0);
            check("r_data", g ? m1_rdata : m0_rdata, base + b);
            check("r_resp", {30'b0, g ? m1_rresp : m0_rresp}, {30'b0, 2'(b)});
            check("r_last", {31'b0, g ? m1_rlast : m0_rlast}, {31'b0, s_rlast});
            @(posedge clock); #1;
            if (rr) begin
                done = s_rlast;
                b++;
            end
        end
        exp_beats = (early_last >= 0) ? early_last + 1 : int'(len) + 1;
        check("txn_done", {31'b0, done}, 1);
        check("beat_count", b, exp_beats);
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
        m0_rready = 1'b0;
        m1_rready = 1'b0;
        #1;
        check("idle_s_arvalid", {31'b0, s_arvalid}, 0);
        check("idle_s_rready", {31'b0, s_rready}, 0);
        check("proto_err", {31'b0, proto_err}, {31'b0, exp_perr});
    endtask

    initial begin
        reset = 1'b0;
        {m0_arvalid, m0_rready, m1_arvalid, m1_rready} = '0;
        m0_araddr = 32'h0000_1000; m0_arlen = 8'd1; m0_arsize = 3'd3; m0_arburst = 2'd1;
        m1_araddr = 32'h0000_2000; m1_arlen = 8'd1; m1_arsize = 3'd2; m1_arburst = 2'd1;
        {s_arready, s_rvalid, s_rlast} = '0;
        s_rdata = '0; s_rresp = '0; s_rid = '0;
        exp_perr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_s_arvalid", {31'b0, s_arvalid}, 0);
        check("rst_s_rready", {31'b0, s_rready}, 0);
        check("rst_m0_arready", {31'b0, m0_arready}, 0);
        check("rst_m1_rvalid", {31'b0, m1_rvalid}, 0);
        check("rst_proto_err", {31'b0, proto_err}, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        txn(2'b11, 1'b0, 1, -1, 0, -1, 32'hA000_0000);
        txn(2'b11, 1'b1, 0, -1, 0, -1, 32'hB000_0000);
        for (int i = 0; i < 6; i++)
            txn(2'b11, 1'(i % 2), 0, -1, 0, -1, 32'hC000_0000 + 32'(i * 16));
        m1_araddr = 32'h8000_0004;
        m1_arlen = 8'd0;
        txn(2'b10, 1'b1, 3, -1, 0, -1, 32'hDEAD_BEEF);
        m0_arlen = 8'd3;
        txn(2'b01, 1'b0, 0, -1, 1, -1, 32'h3000_0000);
        exp_perr = 1'b1;
        txn(2'b01, 1'b0, 0, 1, 0, -1, 32'h4000_0000);
        txn(2'b10, 1'b1, 0, -1, 0, -1, 32'h5000_0000);
        txn(2'b01, 1'b0, 0, -1, 0, 1, 32'h6000_0000);
        exp_perr = 1'b0;
        txn(2'b10, 1'b1, 0, -1, 0, -1, 32'h7000_0000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
